id_operand_stage: RTL and testbench
===================================

// Module: id_operand_stage
// PURPOSE
//  Decode/operand-fetch stage directly upstream of the 32x32 register file.
//  - Accepts one MIPS instruction word per valid/ready handshake.
//  - Drives the register file read addresses and captures the asynchronous S/T read data.
//  - Presents a registered operand bundle (operands, immediate, destination, write flag) to the execute stage.
// PARAMETERS
//  DATA_W  32  operand/instruction width
//  ADDR_W  5   register address width (32 registers)
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high reset
//  inst        in   32      instruction word
//  inst_valid  in   1       inst is valid
//  inst_ready  out  1       stage can accept inst this cycle
//  S_Addr      out  5       regfile read address S = inst[25:21]
//  T_Addr      out  5       regfile read address T = inst[20:16]
//  S           in   32      regfile read data S, combinational from S_Addr
//  T           in   32      regfile read data T, combinational from T_Addr
//  wb_en       in   1       regfile write enable, same signal as regfile D_En
//  wb_addr     in   5       regfile write address, same signal as regfile D_Addr
//  wb_data     in   32      regfile write data, same signal as regfile D
//  op_valid    out  1       operand bundle valid
//  op_ready    in   1       execute stage accepts bundle
//  op_s        out  32      captured operand S
//  op_t        out  32      captured operand T
//  op_imm      out  32      extended immediate
//  op_dest     out  5       destination register
//  op_wr       out  1       bundle writes a register
//  op_opcode   out  6       inst[31:26]
//  op_func     out  6       inst[5:0]
// BEHAVIOUR
//  - Two-state FSM: EMPTY (op_valid=0) and FULL (op_valid=1).
//  - inst_ready = !op_valid | op_ready; combinational, one-deep, no skid buffer.
//  - Accept = inst_valid & inst_ready. On the accept edge, all op_* registers load and the FSM moves to FULL.
//  - Latency is one cycle, from the accept edge to op_valid=1.
//  - op_valid & op_ready without an accept -> EMPTY. Both on the same edge -> stay FULL with the new bundle.
//  - While op_valid=1 and op_ready=0, every op_* output is held stable.
//  - S_Addr and T_Addr always decode the current inst, whether or not it is accepted.
//  - Decode by opcode:
//    - R-type (0x00): dest = rd, imm = 0.
//    - ANDI/ORI/XORI (0x0C/0x0D/0x0E): dest = rt, imm zero-extended.
//    - LUI (0x0F): dest = rt, imm = {inst[15:0], 16'h0}.
//    - Other I-type: dest = rt, imm sign-extended.
//    - JAL (0x03): dest = 31, imm = {6'b0, inst[25:0]}.
//    - J (0x02): imm = {6'b0, inst[25:0]}, op_wr = 0.
//  - op_wr = 0 for SW (0x2B), BEQ (0x04), BNE (0x05) and J (0x02).
//  - op_wr = 0 whenever dest = 0; op_dest is still reported.
//  - Reset: FSM -> EMPTY. op_valid, op_s, op_t, op_imm, op_dest, op_wr, op_opcode and op_func all -> 0.
//  - Reset asserted mid-operation discards the held bundle. inst_ready is 1 on the first cycle after reset.
// CONFIGURATION
//  - Macro ID_FORWARD_EN.
//  - Defined: in the accept cycle, if wb_en, wb_addr != 0 and wb_addr == S_Addr, then op_s captures wb_data, not S. The same rule applies to T_Addr/op_t. Both may forward at once.
//  - Undefined: wb_* inputs are unused. A write landing on the accept edge yields the pre-write register value.
// STRUCTURE
//  - Shared package id_pkg: opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SW), FSM state enum, DATA_W/ADDR_W defaults.
//  - One sub-module, imm_ext: combinational immediate extender (sign, zero, lui, jump modes).
// TESTING
//  1. Reset, then ADDI inst 0x2009FFFF with S=0x5, T=0x7, op_ready=1.
//     Required: next cycle op_valid=1, op_imm=0xFFFFFFFF, op_dest=9, op_wr=1, op_s=0x5.
//  2. R-type add 0x012A4020 accepted, then op_ready=0 for 3 cycles while inst keeps changing.
//     Required: inst_ready=0, op_dest=8 and op_s/op_t held; op_ready=1 with a new inst -> FULL with the new bundle.
//  3. Back-to-back ORI 0x3421F0F0 and LUI 0x3C011234 with op_ready=1.
//     Required: op_imm 0x0000F0F0 then 0x12340000, with no bubble between them.
//  4. SW, BEQ and an R-type with rd=0.
//     Required: op_wr=0 for each; JAL gives op_dest=31, op_wr=1.
//  5. Reset asserted while FULL with op_ready=0.
//     Required: next cycle op_valid=0, all op_* outputs 0, inst_ready=1.
//  6. ID_FORWARD_EN defined: accept with rs=3, wb_en=1, wb_addr=3, wb_data=0xDEADBEEF, S=0x11.
//     Required: op_s=0xDEADBEEF. Same stimulus with wb_addr=0 -> op_s=0x11. With ID_FORWARD_EN undefined -> op_s=0x11.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode constants, FSM state and immediate-mode types for the ID operand stage.
package id_pkg;

   localparam int unsigned DEFAULT_DATA_W = 32;
   localparam int unsigned DEFAULT_ADDR_W = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic {
      StEmpty,
      StFull
   } id_state_e;

   typedef enum logic [2:0] {
      ImmNone,
      ImmSign,
      ImmZero,
      ImmLui,
      ImmJump
   } imm_mode_e;

endpackage

// File: rtl/id_operand_stage_if.sv
// Operand bundle handshake from the ID stage to execute; master is the ID stage.
interface id_operand_stage_if #(
   parameter int unsigned DATA_W = id_pkg::DEFAULT_DATA_W,
   parameter int unsigned ADDR_W = id_pkg::DEFAULT_ADDR_W
) ();

   logic              op_valid;
   logic              op_ready;
   logic [DATA_W-1:0] op_s;
   logic [DATA_W-1:0] op_t;
   logic [DATA_W-1:0] op_imm;
   logic [ADDR_W-1:0] op_dest;
   logic              op_wr;
   logic [5:0]        op_opcode;
   logic [5:0]        op_func;

   modport master (
      output op_valid, op_s, op_t, op_imm, op_dest, op_wr, op_opcode, op_func,
      input  op_ready
   );

   modport slave (
      input  op_valid, op_s, op_t, op_imm, op_dest, op_wr, op_opcode, op_func,
      output op_ready
   );

endinterface

// File: rtl/id_operand_stage_imm_ext.sv
// Combinational immediate extender: none, sign, zero, lui and jump-target modes.
module imm_ext
   import id_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
   input  logic [25:0]       field,
   input  imm_mode_e         mode,
   output logic [DATA_W-1:0] imm
);

   always_comb begin
      imm = '0;
      unique case (mode)
         ImmSign: imm = {{(DATA_W-16){field[15]}}, field[15:0]};
         ImmZero: imm = {{(DATA_W-16){1'b0}}, field[15:0]};
         ImmLui:  imm = {field[15:0], {(DATA_W-16){1'b0}}};
         ImmJump: imm = {{(DATA_W-26){1'b0}}, field};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage feeding execute with a registered one-deep operand bundle.
// Define ID_FORWARD_EN to bypass a same-cycle register file write into the captured operands.
module id_operand_stage
   import id_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W,
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DATA_W-1:0]  inst,
   input  logic               inst_valid,
   output logic               inst_ready,
   output logic [ADDR_W-1:0]  S_Addr,
   output logic [ADDR_W-1:0]  T_Addr,
   input  logic [DATA_W-1:0]  S,
   input  logic [DATA_W-1:0]  T,
   input  logic               wb_en,
   input  logic [ADDR_W-1:0]  wb_addr,
   input  logic [DATA_W-1:0]  wb_data,
   id_operand_stage_if.master op
);

   id_state_e state_q, state_d;

   logic [DATA_W-1:0] op_s_q, op_t_q, op_imm_q;
   logic [ADDR_W-1:0] op_dest_q;
   logic              op_wr_q;
   logic [5:0]        op_opcode_q, op_func_q;

   logic [5:0]        opcode;
   logic [ADDR_W-1:0] rd;
   logic [ADDR_W-1:0] dest_d;
   logic              wr_d;
   logic              wr_ok;
   imm_mode_e         imm_mode;
   logic [DATA_W-1:0] imm_d;
   logic [DATA_W-1:0] s_sel, t_sel;
   logic              op_valid;
   logic              accept;

   assign opcode = inst[31:26];
   assign S_Addr = inst[25:21];
   assign T_Addr = inst[20:16];
   assign rd     = inst[15:11];

   always_comb begin
      imm_mode = ImmSign;
      dest_d   = T_Addr;
      wr_ok    = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            imm_mode = ImmNone;
            dest_d   = rd;
         end
         OP_ANDI, OP_ORI, OP_XORI: imm_mode = ImmZero;
         OP_LUI:   imm_mode = ImmLui;
         OP_JAL: begin
            imm_mode = ImmJump;
            dest_d   = {ADDR_W{1'b1}};
         end
         OP_J: begin
            imm_mode = ImmJump;
            wr_ok    = 1'b0;
         end
         OP_SW, OP_BEQ, OP_BNE: wr_ok = 1'b0;
         default: ;
      endcase
      // Writes to r0 are architecturally dropped, but the field is still reported.
      wr_d = wr_ok && (dest_d != '0);
   end

   imm_ext #(
      .DATA_W (DATA_W)
   ) u_imm_ext (
      .field (inst[25:0]),
      .mode  (imm_mode),
      .imm   (imm_d)
   );

`ifdef ID_FORWARD_EN
   always_comb begin
      s_sel = S;
      t_sel = T;
      if (wb_en && (wb_addr != '0) && (wb_addr == S_Addr)) s_sel = wb_data;
      if (wb_en && (wb_addr != '0) && (wb_addr == T_Addr)) t_sel = wb_data;
   end
`else
   logic unused_wb;
   assign unused_wb = ^{wb_en, wb_addr, wb_data};
   assign s_sel     = S;
   assign t_sel     = T;
`endif

   assign op_valid   = (state_q == StFull);
   assign inst_ready = !op_valid || op.op_ready;
   assign accept     = inst_valid && inst_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StEmpty: if (accept) state_d = StFull;
         StFull:  if (!accept && op.op_ready) state_d = StEmpty;
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StEmpty;
         op_s_q      <= '0;
         op_t_q      <= '0;
         op_imm_q    <= '0;
         op_dest_q   <= '0;
         op_wr_q     <= 1'b0;
         op_opcode_q <= '0;
         op_func_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_s_q      <= s_sel;
            op_t_q      <= t_sel;
            op_imm_q    <= imm_d;
            op_dest_q   <= dest_d;
            op_wr_q     <= wr_d;
            op_opcode_q <= opcode;
            op_func_q   <= inst[5:0];
         end
      end
   end

   assign op.op_valid  = op_valid;
   assign op.op_s      = op_s_q;
   assign op.op_t      = op_t_q;
   assign op.op_imm    = op_imm_q;
   assign op.op_dest   = op_dest_q;
   assign op.op_wr     = op_wr_q;
   assign op.op_opcode = op_opcode_q;
   assign op.op_func   = op_func_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage with hand-computed expected bundles.
module tb_id_operand_stage;

   logic        clk;
   logic        reset;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ready;
   logic [4:0]  S_Addr, T_Addr;
   logic [31:0] S, T;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int n_cmp = 0;
   int n_err = 0;

   id_operand_stage_if op_if ();

   id_operand_stage dut (
      .clk        (clk),
      .reset      (reset),
      .inst       (inst),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .S_Addr     (S_Addr),
      .T_Addr     (T_Addr),
      .S          (S),
      .T          (T),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .op         (op_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bundle(input string tag, input logic [31:0] s_e, input logic [31:0] t_e,
                               input logic [31:0] imm_e, input logic [4:0] dest_e,
                               input logic wr_e);
      check({tag, ".valid"}, {31'b0, op_if.op_valid}, 32'd1);
      check({tag, ".s"},     op_if.op_s, s_e);
      check({tag, ".t"},     op_if.op_t, t_e);
      check({tag, ".imm"},   op_if.op_imm, imm_e);
      check({tag, ".dest"},  {27'b0, op_if.op_dest}, {27'b0, dest_e});
      check({tag, ".wr"},    {31'b0, op_if.op_wr}, {31'b0, wr_e});
   endtask

   initial begin
      reset           = 1'b1;
      inst            = 32'h0;
      inst_valid      = 1'b0;
      S               = 32'h0;
      T               = 32'h0;
      wb_en           = 1'b0;
      wb_addr         = 5'd0;
      wb_data         = 32'h0;
      op_if.op_ready  = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("rst.valid", {31'b0, op_if.op_valid}, 32'd0);
      check("rst.ready", {31'b0, inst_ready}, 32'd1);
      check("rst.s", op_if.op_s, 32'h0);

      // ADDI $9, $0, -1
      inst = 32'h2009FFFF; inst_valid = 1'b1; S = 32'h5; T = 32'h7; op_if.op_ready = 1'b1;
      #1;
      check("addi.saddr", {27'b0, S_Addr}, 32'd0);
      check("addi.taddr", {27'b0, T_Addr}, 32'd9);
      tick();
      check_bundle("addi", 32'h5, 32'h7, 32'hFFFFFFFF, 5'd9, 1'b1);
      check("addi.opcode", {26'b0, op_if.op_opcode}, 32'h08);
      check("addi.func", {26'b0, op_if.op_func}, 32'h3F);

      // add $8, $9, $10 accepted while FULL, then stalled
      inst = 32'h012A4020; S = 32'h100; T = 32'h200;
      tick();
      check_bundle("add", 32'h100, 32'h200, 32'h0, 5'd8, 1'b1);
      op_if.op_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         inst = 32'h20420000 + i * 32'h00210001;
         S    = 32'h900 + i;
         T    = 32'hA00 + i;
         #1;
         check("stall.ready", {31'b0, inst_ready}, 32'd0);
         tick();
         check_bundle("stall", 32'h100, 32'h200, 32'h0, 5'd8, 1'b1);
      end

      // ORI then LUI back to back
      op_if.op_ready = 1'b1;
      inst = 32'h3421F0F0; S = 32'hAAAA0000; T = 32'h1;
      #1;
      check("ori.ready", {31'b0, inst_ready}, 32'd1);
      tick();
      check_bundle("ori", 32'hAAAA0000, 32'h1, 32'h0000F0F0, 5'd1, 1'b1);
      inst = 32'h3C011234; S = 32'h0; T = 32'h2;
      tick();
      check_bundle("lui", 32'h0, 32'h2, 32'h12340000, 5'd1, 1'b1);

      // XORI with negative-looking immediate stays zero-extended
      inst = 32'h3843FFFF; S = 32'h3; T = 32'h4;
      tick();
      check_bundle("xori", 32'h3, 32'h4, 32'h0000FFFF, 5'd3, 1'b1);

      // Non-writing instructions
      inst = 32'hAC220004;
      tick();
      check_bundle("sw", 32'h3, 32'h4, 32'h4, 5'd2, 1'b0);
      check("sw.opcode", {26'b0, op_if.op_opcode}, 32'h2B);
      inst = 32'h1022FFFE;
      tick();
      check_bundle("beq", 32'h3, 32'h4, 32'hFFFFFFFE, 5'd2, 1'b0);
      inst = 32'h00220020;
      tick();
      check_bundle("rd0", 32'h3, 32'h4, 32'h0, 5'd0, 1'b0);
      inst = 32'h0C000010;
      tick();
      check_bundle("jal", 32'h3, 32'h4, 32'h10, 5'd31, 1'b1);

      // Drain: valid with ready and no new inst empties the stage
      inst_valid = 1'b0;
      tick();
      check("drain.valid", {31'b0, op_if.op_valid}, 32'd0);
      check("drain.ready", {31'b0, inst_ready}, 32'd1);

      // Reset while FULL and stalled
      inst = 32'h2009FFFF; inst_valid = 1'b1; S = 32'h5; T = 32'h7;
      tick();
      op_if.op_ready = 1'b0;
      tick();
      check("prerst.valid", {31'b0, op_if.op_valid}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0; inst_valid = 1'b0;
      #1;
      check("midrst.valid", {31'b0, op_if.op_valid}, 32'd0);
      check("midrst.ready", {31'b0, inst_ready}, 32'd1);
      check("midrst.s", op_if.op_s, 32'h0);
      check("midrst.imm", op_if.op_imm, 32'h0);
      check("midrst.dest", {27'b0, op_if.op_dest}, 32'd0);
      check("midrst.wr", {31'b0, op_if.op_wr}, 32'd0);
      check("midrst.opc", {26'b0, op_if.op_opcode}, 32'd0);
      check("midrst.func", {26'b0, op_if.op_func}, 32'd0);

      // Write-back bypass: ADDI $4, $3, 1
      op_if.op_ready = 1'b1;
      inst = 32'h20640001; inst_valid = 1'b1; S = 32'h11; T = 32'h22;
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
      tick();
`ifdef ID_FORWARD_EN
      check("fwd.s", op_if.op_s, 32'hDEADBEEF);
`else
      check("fwd.s", op_if.op_s, 32'h11);
`endif
      check("fwd.t", op_if.op_t, 32'h22);
      wb_addr = 5'd0;
      tick();
      check("fwd0.s", op_if.op_s, 32'h11);
      wb_addr = 5'd4;
      tick();
      check("fwdt.s", op_if.op_s, 32'h11);
`ifdef ID_FORWARD_EN
      check("fwdt.t", op_if.op_t, 32'hDEADBEEF);
`else
      check("fwdt.t", op_if.op_t, 32'h22);
`endif
      wb_en = 1'b0;
      tick();
      check("nofwd.t", op_if.op_t, 32'h22);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
